// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; result lands WIDTH cycles after start (1 cycle on divide-by-zero).
// No backpressure: start is taken only when idle, and start/mthi/mtlo are dropped while busy.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] dvsr;
  logic             is_div;
  logic             zdiv;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic             bz;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    sgn   = SIGNED_EN && !op[0];
    bz    = op[1] && (b == '0);
    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvsr} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, dvsr});
    rem_sub = shifted[WIDTH-1:0] - dvsr;
    if (is_div) begin
      nxt_hi = q_bit ? rem_sub : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], q_bit};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final step's result as it is committed.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    if (zdiv) begin
      res_hi = acc_lo;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = neg_r ? -nxt_hi : nxt_hi;
      res_lo = neg_q ? -nxt_lo : nxt_lo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      dvsr   <= '0;
      is_div <= 1'b0;
      zdiv   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hiwe) hi <= wd;
          if (lowe) lo <= wd;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            dz     <= 1'b0;
            acc_hi <= '0;
            // A zero divisor keeps the raw dividend and jumps to the final step.
            acc_lo <= bz ? a : mag_a;
            dvsr   <= mag_b;
            is_div <= op[1];
            zdiv   <= bz;
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn && a[WIDTH-1];
            cnt    <= bz ? LAST : '0;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            hi    <= res_hi;
            lo    <= res_lo;
            dz    <= zdiv;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table on a 32-bit instance plus hand sequences
// for RUN-time drops, IDLE writes, back-to-back starts, reset abort and an 8-bit instance.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        hiwe, lowe;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8;
  logic        hiwe8, lowe8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int ncmp = 0;
  int nerr = 0;

  muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hiwe(hiwe), .lowe(lowe), .wd(wd),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hiwe(hiwe8), .lowe(lowe8), .wd(wd8),
    .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Counts edges until done; also counts busy cycles and checks hi/lo hold their values.
  task automatic wait_done32(input string tag, output int n, output int bc, output bit stable);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; bc = 0; stable = 1'b1;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      tick();
      n++;
    end
    chk({tag, " done seen"}, 64'(done), 64'd1);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n, bc;
    bit st;
    string t;
    t = $sformatf("vec%0d", idx);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    wait_done32(t, n, bc, st);
    chk({t, " latency"}, 64'(n), 64'(v.lat));
    chk({t, " busy cycles"}, 64'(bc), 64'(v.lat));
    chk({t, " hi/lo stable in RUN"}, 64'(st), 64'd1);
    chk({t, " hi"}, 64'(hi), 64'(v.hi));
    chk({t, " lo"}, 64'(lo), 64'(v.lo));
    chk({t, " dz"}, 64'(dz), 64'(v.dz));
    tick();
    chk({t, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, bc;
    bit st;
    logic [31:0] h0;

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; wd = '0; hiwe = 1'b0; lowe = 1'b0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wd8 = '0; hiwe8 = 1'b0; lowe8 = 1'b0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
    vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 32};
    vecs[5]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[6]  = '{2'b01, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b0, 32};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
    vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
    vecs[9]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32};
    vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
    vecs[11] = '{2'b10, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 32};
    vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};

    tick(); tick();
    chk("reset u32 hi/lo", {hi, lo}, 64'd0);
    chk("reset u32 busy/done/dz", 64'({busy, done, dz}), 64'd0);
    chk("reset u8 state", 64'({hi8, lo8, busy8, done8, dz8}), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_op(vecs[i], i);

    // start and hiwe during RUN are both dropped.
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    h0 = hi;
    for (int i = 0; i < 5; i++) tick();
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; hiwe = 1'b1; wd = 32'hAAAA5555;
    tick();
    start = 1'b0; hiwe = 1'b0;
    chk("run hiwe dropped", 64'(hi), 64'(h0));
    wait_done32("run drop", n, bc, st);
    chk("run drop latency", 64'(n + 6), 64'd32);
    chk("run drop result", {hi, lo}, 64'h00000000_0000000F);
    tick();
    chk("run start not queued", 64'(busy), 64'd0);

    // mthi / mtlo in IDLE.
    hiwe = 1'b1; wd = 32'hAAAA5555;
    tick();
    hiwe = 1'b0;
    chk("idle mthi", {hi, lo}, 64'hAAAA5555_0000000F);
    lowe = 1'b1; wd = 32'h12345678;
    tick();
    lowe = 1'b0;
    chk("idle mtlo", {hi, lo}, 64'hAAAA5555_12345678);

    // start plus hiwe in the same IDLE cycle: write lands, then the result overwrites it.
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; hiwe = 1'b1; wd = 32'hDEADBEEF;
    tick();
    start = 1'b0; hiwe = 1'b0;
    chk("start+hiwe write", 64'(hi), 64'hDEADBEEF);
    wait_done32("start+hiwe", n, bc, st);
    chk("start+hiwe latency", 64'(n), 64'd32);
    chk("start+hiwe result", {hi, lo}, 64'h00000000_00000006);

    // Back-to-back start in the done cycle.
    op = 2'b01; a = 32'd4; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b accepted", 64'({busy, done}), 64'b10);
    wait_done32("b2b", n, bc, st);
    chk("b2b latency", 64'(n), 64'd32);
    chk("b2b result", {hi, lo}, 64'h00000000_00000014);

    // Writes in the done cycle apply at the following edge.
    hiwe = 1'b1; lowe = 1'b1; wd = 32'hCAFEF00D;
    tick();
    hiwe = 1'b0; lowe = 1'b0;
    chk("done-cycle write", {hi, lo}, 64'hCAFEF00D_CAFEF00D);

    // Reset in the middle of a MULT aborts with no result.
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    #1;
    chk("abort busy/done/dz", 64'({busy, done, dz}), 64'd0);
    chk("abort hi/lo", {hi, lo}, 64'd0);
    #2;
    reset = 1'b1;
    tick();

    // 8-bit instance: 0x80 * 0x80.
    op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    n = 0;
    while (!done8 && n < 50) begin
      tick();
      n++;
    end
    chk("w8 done seen", 64'(done8), 64'd1);
    chk("w8 latency", 64'(n), 64'd8);
    chk("w8 result", 64'({hi8, lo8}), 64'h4000);
    chk("u32 idle after abort", 64'({busy, hi, lo}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
